// File: rtl/sim_cycle_monitor.sv
// Simulation cycle monitor: authoritative cycle count, waveform-dump window FSM,
// dump_end timeout and a progress watchdog that feed the harness finish logic.
module sim_cycle_monitor #(
  parameter int CNT_W  = 64,
  parameter int WDOG_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cfg_dump_start,
  input  logic [CNT_W-1:0]  cfg_dump_end,
  input  logic [WDOG_W-1:0] cfg_wdog_limit,
  input  logic              progress,
  output logic [CNT_W-1:0]  cycle,
  output logic              dump_active,
  output logic              dump_start_pulse,
  output logic              timeout,
  output logic              wdog_expired,
  output logic              run_done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DUMP    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    start_q, start_d;
  logic [CNT_W-1:0]    end_q, end_d;
  logic [WDOG_W-1:0]   limit_q, limit_d;
  logic [WDOG_W-1:0]   wcnt_q, wcnt_d;
  logic                pulse_q, pulse_d;
  logic                timeout_q, timeout_d;
  logic                wdog_q, wdog_d;
  logic                done_q, done_d;

  logic                capture;
  logic                cyc_sat;
  logic [CNT_W-1:0]    start_eff;
  logic [CNT_W-1:0]    end_eff;
  logic                hit_start;
  logic                hit_end;
  logic                wdog_active;
  logic [WDOG_W-1:0]   wcnt_inc;

  always_comb begin
    capture   = (state_q == ST_CAPTURE);
    cyc_sat   = &cycle_q;
    cycle_d   = cyc_sat ? cycle_q : cycle_q + 1'b1;
    // On the capture edge the live config is used, later the captured copy.
    start_eff = capture ? cfg_dump_start : start_q;
    end_eff   = capture ? cfg_dump_end   : end_q;
    start_d   = capture ? cfg_dump_start : start_q;
    end_d     = capture ? cfg_dump_end   : end_q;
    limit_d   = capture ? cfg_wdog_limit : limit_q;

    // A saturated counter no longer "becomes" anything, so it cannot re-trigger.
    hit_end   = !cyc_sat && (end_eff != '0) && (cycle_d == end_eff);
    hit_start = capture ? ((start_eff == '0) || (cycle_d == start_eff))
                        : (!cyc_sat && (cycle_d == start_eff));

    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_CAPTURE, ST_WAIT: begin
        if (hit_end) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else if (hit_start) begin
          state_d = ST_DUMP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DUMP: begin
        if (hit_end) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_DONE;
    endcase

    pulse_d = (state_d == ST_DUMP) && (state_q != ST_DUMP);

    wdog_active = (limit_q != '0) && !capture;
    wcnt_inc    = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
    wcnt_d      = wcnt_q;
    wdog_d      = wdog_q;
    if (wdog_active) begin
      if (progress) begin
        wcnt_d = '0;
      end else begin
        wcnt_d = wcnt_inc;
        if (wcnt_inc == limit_q) wdog_d = 1'b1;
      end
    end

    done_d = timeout_q | wdog_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CAPTURE;
      cycle_q   <= '0;
      start_q   <= '0;
      end_q     <= '0;
      limit_q   <= '0;
      wcnt_q    <= '0;
      pulse_q   <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      start_q   <= start_d;
      end_q     <= end_d;
      limit_q   <= limit_d;
      wcnt_q    <= wcnt_d;
      pulse_q   <= pulse_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
      done_q    <= done_d;
    end
  end

  assign cycle            = cycle_q;
  assign dump_active      = (state_q == ST_DUMP);
  assign dump_start_pulse = pulse_q;
  assign timeout          = timeout_q;
  assign wdog_expired     = wdog_q;
  assign run_done         = done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sim_cycle_monitor.sv
// Directed bench for sim_cycle_monitor: each scenario resets, runs a number of
// cycles and compares every output against hand-derived per-cycle expectations.
module tb_sim_cycle_monitor;

  logic        clock;
  logic        reset;
  logic [63:0] cfg_dump_start;
  logic [63:0] cfg_dump_end;
  logic [31:0] cfg_wdog_limit;
  logic        progress;
  logic [63:0] cycle;
  logic        dump_active;
  logic        dump_start_pulse;
  logic        timeout;
  logic        wdog_expired;
  logic        run_done;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  sim_cycle_monitor #(.CNT_W(64), .WDOG_W(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .cfg_dump_start   (cfg_dump_start),
    .cfg_dump_end     (cfg_dump_end),
    .cfg_wdog_limit   (cfg_wdog_limit),
    .progress         (progress),
    .cycle            (cycle),
    .dump_active      (dump_active),
    .dump_start_pulse (dump_start_pulse),
    .timeout          (timeout),
    .wdog_expired     (wdog_expired),
    .run_done         (run_done),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cycle"},   cycle,            64'd0);
    check({tag, "_active"},  dump_active,      64'd0);
    check({tag, "_pulse"},   dump_start_pulse, 64'd0);
    check({tag, "_timeout"}, timeout,          64'd0);
    check({tag, "_wdog"},    wdog_expired,     64'd0);
    check({tag, "_done"},    run_done,         64'd0);
  endtask

  // Applies config, holds reset for one cycle, releases on a falling edge.
  task automatic start_run(input logic [63:0] s, input logic [63:0] e, input logic [31:0] l);
    reset          = 1'b0;
    progress       = 1'b0;
    cfg_dump_start = s;
    cfg_dump_end   = e;
    cfg_wdog_limit = l;
    @(negedge clock);
    check_idle("rst");
    reset = 1'b1;
  endtask

  task automatic expect_cycle(input string sc, input int c, input bit act, input bit pls,
                              input bit to, input bit wd, input bit rd);
    check($sformatf("%s_c%0d_cycle", sc, c),   cycle,            64'(c));
    check($sformatf("%s_c%0d_active", sc, c),  dump_active,      64'(act));
    check($sformatf("%s_c%0d_pulse", sc, c),   dump_start_pulse, 64'(pls));
    check($sformatf("%s_c%0d_timeout", sc, c), timeout,          64'(to));
    check($sformatf("%s_c%0d_wdog", sc, c),    wdog_expired,     64'(wd));
    check($sformatf("%s_c%0d_done", sc, c),    run_done,         64'(rd));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    progress = 1'b0;
    cfg_dump_start = '0;
    cfg_dump_end   = '0;
    cfg_wdog_limit = '0;
    repeat (2) @(negedge clock);

    // free run: dump from release, no timeout, no watchdog
    start_run(64'd0, 64'd0, 32'd0);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      expect_cycle("free", c, 1'b1, c == 1, 1'b0, 1'b0, 1'b0);
    end

    // window 10..20
    start_run(64'd10, 64'd20, 32'd0);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clock);
      expect_cycle("win", c, (c >= 10) && (c < 20), c == 10, c >= 20, 1'b0, c >= 21);
    end

    // end before start: never dumps
    start_run(64'd15, 64'd8, 32'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      expect_cycle("inv", c, 1'b0, 1'b0, c >= 8, 1'b0, c >= 9);
    end

    // equal start and end: done wins
    start_run(64'd6, 64'd6, 32'd0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      expect_cycle("eq", c, 1'b0, 1'b0, c >= 6, 1'b0, c >= 7);
    end

    // watchdog limit 5, progress at cycles 3 and 7
    start_run(64'd0, 64'd0, 32'd5);
    for (int c = 1; c <= 16; c++) begin
      progress = (c == 3) || (c == 7);
      @(negedge clock);
      expect_cycle("wd", c, 1'b1, c == 1, 1'b0, c >= 12, c >= 13);
    end
    progress = 1'b0;

    // progress exactly on the would-expire cycle 8 keeps the flag clear
    start_run(64'd0, 64'd0, 32'd5);
    for (int c = 1; c <= 15; c++) begin
      progress = (c == 3) || (c == 8);
      @(negedge clock);
      expect_cycle("wdsave", c, 1'b1, c == 1, 1'b0, c >= 13, c >= 14);
    end
    progress = 1'b0;

    // timeout and watchdog expiry on the same edge (cycle 7)
    start_run(64'd0, 64'd7, 32'd6);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      expect_cycle("both", c, c < 7, c == 1, c >= 7, c >= 7, c >= 8);
    end

    // config changed after capture is ignored
    start_run(64'd10, 64'd20, 32'd0);
    for (int c = 1; c <= 21; c++) begin
      if (c == 4) begin
        cfg_dump_start = 64'd4;
        cfg_dump_end   = 64'd5;
        cfg_wdog_limit = 32'd1;
      end
      @(negedge clock);
      expect_cycle("late", c, (c >= 10) && (c < 20), c == 10, c >= 20, 1'b0, c >= 21);
    end

    // async reset mid-run, recapture with a new start
    start_run(64'd5, 64'd100, 32'd0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      expect_cycle("pre", c, c >= 5, c == 5, 1'b0, 1'b0, 1'b0);
    end
    #2 reset = 1'b0;
    #1 check_idle("async");
    cfg_dump_start = 64'd2;
    cfg_dump_end   = 64'd0;
    @(negedge clock);
    check_idle("held");
    reset = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      expect_cycle("post", c, c >= 2, c == 2, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_cycle_monitor.md
Name: sim_cycle_monitor

Overview:
- Testbench-side stage directly downstream of the simulation clock/reset generator.
- Consumes the generated clock and reset and keeps the authoritative cycle count.
- Decides the waveform-dump window (start/end cycle) and raises end-of-run conditions: dump_end timeout, and a no-progress watchdog fed by DUT retire pulses.
- Outputs drive the dump-control and finish/fatal logic of the top-level harness.

Parameters:
- CNT_W, 64, width of cycle counter and cycle-based config inputs.
- WDOG_W, 32, width of watchdog counter and limit.

Ports:
- clock  input  1  simulation clock from the clock generator.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- cfg_dump_start  input  CNT_W  first dumped cycle; 0 = dump from release.
- cfg_dump_end  input  CNT_W  timeout cycle; 0 = no timeout.
- cfg_wdog_limit  input  WDOG_W  max cycles without progress; 0 = watchdog disabled.
- progress  input  1  one-cycle pulse per retired instruction/transaction.
- cycle  output  CNT_W  rising edges since reset release, saturating.
- dump_active  output  1  high while inside the dump window.
- dump_start_pulse  output  1  one-cycle pulse on the first dump_active cycle.
- timeout  output  1  sticky; cycle reached cfg_dump_end.
- wdog_expired  output  1  sticky; watchdog limit reached.
- run_done  output  1  timeout | wdog_expired, registered.

Behaviour:
- Reset low (async):
  - cycle=0, all outputs 0, FSM=CAPTURE, watchdog count=0.
  - Reset asserted mid-run aborts everything; config is recaptured after the next release.
- Config capture:
  - cfg_* are sampled only at the first rising edge after release (FSM CAPTURE).
  - Later changes are ignored until the next reset.
- cycle:
  - Increments by 1 on every rising edge after release.
  - Saturates at all-ones and never wraps.
  - The first edge after release produces cycle=1.
- FSM states: CAPTURE, WAIT, DUMP, DONE.
  - CAPTURE -> DUMP if cfg_dump_start==0; otherwise CAPTURE -> WAIT.
  - WAIT -> DUMP on the edge where cycle becomes cfg_dump_start.
  - WAIT or DUMP -> DONE on the edge where cycle becomes cfg_dump_end (cfg_dump_end≠0).
  - If start and end are equal, DONE wins and no dump occurs.
  - If cfg_dump_end < cfg_dump_start (end≠0), the block reaches DONE without dumping.
  - DONE is terminal until reset.
- Outputs per state:
  - dump_active = (state==DUMP), registered, so it updates on the same edge as the state.
  - dump_start_pulse is high exactly for the first cycle dump_active is 1, once per reset epoch.
- timeout:
  - Set on the same edge as the transition to DONE caused by cfg_dump_end; sticky.
- Watchdog:
  - Active only when cfg_wdog_limit≠0 and state≠CAPTURE.
  - Count clears to 0 on any edge with progress=1; otherwise it increments (saturating).
  - wdog_expired sets on the edge where the count becomes cfg_wdog_limit; sticky.
  - progress and the limit-reaching edge coinciding: progress wins and the count clears.
  - Expiry does not change the dump FSM.
- run_done:
  - Registered OR of timeout and wdog_expired, so it lags them by one cycle.
  - Harness treats run_done as final.
- Simultaneous events:
  - timeout and watchdog expiry on the same edge set both flags.
  - Saturated cycle never re-triggers start/end.

Test Plan:
- Start=0, end=0, limit=0, run 50 cycles:
  - dump_active=1 from cycle 1; dump_start_pulse only at cycle 1.
  - timeout, wdog_expired and run_done stay 0.
- Start=10, end=20:
  - dump_active rises on the edge to cycle=10 and falls on the edge to cycle=20.
  - timeout=1 at cycle 20; run_done=1 at cycle 21.
- Start=15, end=8: no dump_active ever; timeout=1 at cycle=8.
- Limit=5, progress pulses at cycles 3 and 7, then none: wdog_expired=1 at cycle 12. Separately, progress exactly at the would-expire cycle must keep the flag at 0.
- Start=5, end=100, reset driven low at cycle 30 (mid-edge, async), cfg changed to start=2, released:
  - All outputs 0 immediately while reset is low.
  - After release: cycle restarts at 1; new dump_start_pulse at cycle 2.
- Change cfg_dump_start after capture: no effect on the window.
